mpc_mul_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined signed 21x15 multiplier between N requesters in the MPC datapath. It drives the multiplier operands and clock enable, and tags each issued product with its requester ID. Each 36-bit result is routed back to the owning requester with a valid/ready handshake. When a result is not accepted, the arbiter stalls the whole multiplier pipeline through `ce` instead of dropping the result.

---
 rtl/mpc_mul_arbiter.sv | 134 +++++++++++++
 tb/tb_mpc_mul_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_mul_arbiter.sv
// mpc_mul_arbiter
//   Round-robin arbiter sharing one pipelined signed 21x15 multiplier between
//   N requesters. Each issued operand pair is tagged with its requester ID in
//   a LAT-deep tag pipeline that mirrors the multiplier registers. The product
//   at the pipeline exit is routed back to its owner with valid/ready. An
//   unaccepted result freezes the whole multiplier (and tags) via mul_ce.
//
// Ports
//   clk        : clock, all logic on rising edge
//   rst        : synchronous active-low reset
//   req_valid  : per-requester operand valid
//   req_a/b    : packed operands, requester i at [21i+20:21i] / [15i+14:15i]
//   req_ready  : one-hot grant (combinational, same cycle as request)
//   res_valid  : one-hot owner of the product at the pipeline exit
//   res_ready  : per-requester result accept
//   res_p      : shared signed product (pass-through of mul_p)
//   mul_a/b    : operands to the multiplier (0 when nothing is granted)
//   mul_ce     : multiplier clock enable (low while the exit result is stuck)
//   mul_p      : multiplier product
//   inflight   : number of valid tags in the pipeline

module mpc_mul_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 3,
    parameter int IDW = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             req_valid,
    input  logic [N*21-1:0]          req_a,
    input  logic [N*15-1:0]          req_b,
    output logic [N-1:0]             req_ready,
    output logic [N-1:0]             res_valid,
    input  logic [N-1:0]             res_ready,
    output logic [35:0]              res_p,
    output logic [20:0]              mul_a,
    output logic [14:0]              mul_b,
    output logic                     mul_ce,
    input  logic [35:0]              mul_p,
    output logic [$clog2(LAT+1)-1:0] inflight
);

    localparam int          CW = $clog2(LAT+1);
    localparam int unsigned NU = N;

    // Tag pipeline: bit/field k is stage k; stage LAT-1 is the exit.
    logic [LAT-1:0]     tag_v_q,  tag_v_d;
    logic [LAT*IDW-1:0] tag_id_q, tag_id_d;
    logic [IDW-1:0]     ptr_q,    ptr_d;
    logic [CW-1:0]      inflight_q, inflight_d;

    logic [20:0]    a_arr [N];
    logic [14:0]    b_arr [N];
    logic [IDW-1:0] exit_id;
    logic           stall;
    logic           found;
    logic           granted;
    logic           complete;
    logic [IDW-1:0] gnt_id;

    assign exit_id = tag_id_q[LAT*IDW-1 -: IDW];

    for (genvar i = 0; i < N; i++) begin : g_port
        assign a_arr[i]     = req_a[21*i +: 21];
        assign b_arr[i]     = req_b[15*i +: 15];
        assign res_valid[i] = tag_v_q[LAT-1] && (exit_id == IDW'(i));
    end

    assign stall    = tag_v_q[LAT-1] & ~res_ready[exit_id];
    assign mul_ce   = ~stall;
    assign complete = tag_v_q[LAT-1] & ~stall;

    // Rotating priority search: offsets 0..N-1 from ptr, wrapped modulo N
    // (N need not be a power of two, so the wrap is explicit).
    always_comb begin
        logic [31:0]    idx;
        logic [IDW-1:0] cand;
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NU; k++) begin
            idx = {{(32-IDW){1'b0}}, ptr_q} + k;
            if (idx >= NU) begin
                idx = idx - NU;
            end
            cand = idx[IDW-1:0];
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
    end

    // Reset low or a stalled exit suppresses any grant.
    assign granted   = found & ~stall & rst;
    assign req_ready = granted ? (N'(1) << gnt_id) : '0;
    assign mul_a     = granted ? a_arr[gnt_id] : '0;
    assign mul_b     = granted ? b_arr[gnt_id] : '0;

    always_comb begin
        logic [31:0] nxt;
        tag_v_d    = tag_v_q;
        tag_id_d   = tag_id_q;
        ptr_d      = ptr_q;
        inflight_d = inflight_q + CW'(granted) - CW'(complete);
        nxt        = {{(32-IDW){1'b0}}, gnt_id} + 32'd1;
        if (mul_ce) begin
            tag_v_d  = (tag_v_q << 1) | LAT'(granted);
            tag_id_d = (tag_id_q << IDW) | (LAT*IDW)'(granted ? gnt_id : '0);
        end
        if (granted) begin
            ptr_d = (nxt >= NU) ? '0 : nxt[IDW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_v_q    <= '0;
            tag_id_q   <= '0;
            ptr_q      <= '0;
            inflight_q <= '0;
        end else begin
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
        end
    end

    assign res_p    = mul_p;
    assign inflight = inflight_q;

endmodule

// File: tb/tb_mpc_mul_arbiter.sv
module tb_mpc_mul_arbiter;

    localparam int N   = 4;
    localparam int LAT = 3;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*21-1:0] req_a;
    logic [N*15-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    res_valid;
    logic [N-1:0]    res_ready;
    logic [35:0]     res_p;
    logic [20:0]     mul_a;
    logic [14:0]     mul_b;
    logic            mul_ce;
    logic [35:0]     mul_p;
    logic [1:0]      inflight;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mpc_mul_arbiter #(.N(N), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_p(res_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_ce(mul_ce), .mul_p(mul_p),
        .inflight(inflight)
    );

    // Attached multiplier: LAT registers, all enabled by mul_ce.
    logic signed [35:0] mpipe [LAT];
    always @(posedge clk) begin
        if (mul_ce) begin
            mpipe[0] <= 36'($signed(mul_a)) * 36'($signed(mul_b));
            for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
        end
    end
    assign mul_p = mpipe[LAT-1];

    // Reference model: ordered list of outstanding results, each aging by one
    // per enabled clock; the oldest is presented once it has aged LAT clocks.
    typedef struct {
        int                 id;
        logic signed [35:0] p;
        int                 age;
    } ent_t;

    ent_t               mq[$];
    int                 m_ptr = 0;
    bit                 e_exit, e_grant, e_ce;
    int                 e_g;
    logic [N-1:0]       e_ready, e_rvalid;
    logic [20:0]        e_a;
    logic [14:0]        e_b;
    logic signed [35:0] e_p;
    int                 e_inflight;

    task automatic model_expect();
        int j;
        e_exit   = (mq.size() > 0) && (mq[0].age == LAT);
        e_rvalid = '0;
        e_ce     = 1'b1;
        e_p      = '0;
        if (e_exit) begin
            e_rvalid = N'(1) << mq[0].id;
            e_ce     = res_ready[mq[0].id];
            e_p      = mq[0].p;
        end
        e_grant = 1'b0;
        e_g     = 0;
        if (e_ce && rst) begin
            for (int off = 0; off < N; off++) begin
                j = (m_ptr + off) % N;
                if (!e_grant && req_valid[j]) begin
                    e_grant = 1'b1;
                    e_g     = j;
                end
            end
        end
        e_ready    = e_grant ? (N'(1) << e_g) : '0;
        e_a        = e_grant ? req_a[21*e_g +: 21] : '0;
        e_b        = e_grant ? req_b[15*e_g +: 15] : '0;
        e_inflight = mq.size();
    endtask

    task automatic model_commit();
        ent_t e;
        if (!rst) begin
            mq.delete();
            m_ptr = 0;
        end else if (e_ce) begin
            if (e_exit) void'(mq.pop_front());
            foreach (mq[k]) mq[k].age++;
            if (e_grant) begin
                e.id  = e_g;
                e.p   = 36'($signed(e_a)) * 36'($signed(e_b));
                e.age = 1;
                mq.push_back(e);
                m_ptr = (e_g + 1) % N;
            end
        end
    endtask

    task automatic settle();
        #4;
        model_expect();
    endtask

    task automatic advance();
        model_expect();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_op(input int i, input logic [20:0] a, input logic [14:0] b);
        req_a[21*i +: 21] = a;
        req_b[15*i +: 15] = b;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = '1; res_ready = '1; req_a = '1; req_b = '1;
        settle();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_forced: got %b want 0000", req_ready); end
        checks++; if (mul_a !== 21'd0) begin errors++; $display("FAIL reset_mul_a_forced: got %h want 0", mul_a); end
        advance();
        req_valid = '0;
        advance();
        rst = 1'b1;
        settle();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL reset_res_valid: got %b want 0000", res_valid); end
        checks++; if (mul_ce !== 1'b1) begin errors++; $display("FAIL reset_mul_ce: got %b want 1", mul_ce); end
        checks++; if (mul_a !== 21'd0 || mul_b !== 15'd0) begin errors++; $display("FAIL reset_operands: got %h/%h want 0/0", mul_a, mul_b); end
        checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        advance();
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        set_op(2, 21'h100000, 15'd16383);
        settle();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        checks++; if (mul_a !== 21'h100000 || mul_b !== 15'd16383) begin errors++; $display("FAIL single_operands: got %h/%h want 100000/3fff", mul_a, mul_b); end
        advance();
        req_valid = '0;
        for (int k = 1; k <= LAT; k++) begin
            settle();
            checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL single_inflight_t%0d: got %0d want 1", k, inflight); end
            if (k == LAT) begin
                checks++; if (res_valid !== 4'b0100) begin errors++; $display("FAIL single_res_valid: got %b want 0100", res_valid); end
                checks++; if (res_p !== -36'sd17178820608) begin errors++; $display("FAIL single_res_p: got %0d want -17178820608", $signed(res_p)); end
            end else begin
                checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL single_early_valid_t%0d: got %b want 0000", k, res_valid); end
            end
            advance();
        end
        settle();
        checks++; if (inflight !== 2'd0 || res_valid !== 4'b0000) begin errors++; $display("FAIL single_drained: got inflight=%0d valid=%b want 0/0000", inflight, res_valid); end
        advance();
    endtask

    task automatic test_backpressure();
        // pointer sits at 3 after the single test, so req 1 wins via wrap
        req_valid = 4'b0010;
        set_op(1, 21'd5, -15'sd7);
        settle();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        advance();
        req_valid = '0;
        advance();
        advance();
        req_valid = '1; res_ready = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++; if (mul_ce !== 1'b0) begin errors++; $display("FAIL bp_ce_c%0d: got %b want 0", k, mul_ce); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_c%0d: got %b want 0000", k, req_ready); end
            checks++; if (res_valid !== 4'b0010) begin errors++; $display("FAIL bp_valid_c%0d: got %b want 0010", k, res_valid); end
            checks++; if (res_p !== -36'sd35) begin errors++; $display("FAIL bp_res_p_c%0d: got %0d want -35", k, $signed(res_p)); end
            advance();
        end
        req_valid = '0; res_ready = '1;
        settle();
        checks++; if (mul_ce !== 1'b1 || res_valid !== 4'b0010 || res_p !== -36'sd35) begin errors++; $display("FAIL bp_release: got ce=%b valid=%b p=%0d want 1/0010/-35", mul_ce, res_valid, $signed(res_p)); end
        advance();
        settle();
        checks++; if (inflight !== 2'd0 || res_valid !== 4'b0000) begin errors++; $display("FAIL bp_no_dup: got inflight=%0d valid=%b want 0/0000", inflight, res_valid); end
        advance();
    endtask

    task automatic test_contention();
        rst = 1'b0;
        advance();
        rst = 1'b1; res_ready = '1; req_valid = '1;
        for (int k = 0; k < 12 + LAT; k++) begin
            if (k == 12) req_valid = '0;
            for (int i = 0; i < N; i++) set_op(i, 21'($urandom), 15'($urandom));
            settle();
            if (k < 12) begin
                checks++; if (req_ready !== (N'(1) << (k % N))) begin errors++; $display("FAIL cont_grant_k%0d: got %b want %b", k, req_ready, N'(1) << (k % N)); end
            end
            if (k >= LAT) begin
                checks++; if (res_valid !== (N'(1) << ((k - LAT) % N))) begin errors++; $display("FAIL cont_route_k%0d: got %b want %b", k, res_valid, N'(1) << ((k - LAT) % N)); end
                checks++; if (res_p !== e_p) begin errors++; $display("FAIL cont_res_p_k%0d: got %0d want %0d", k, $signed(res_p), e_p); end
            end else begin
                checks++; if (inflight !== 2'(k)) begin errors++; $display("FAIL cont_inflight_k%0d: got %0d want %0d", k, inflight, k); end
            end
            advance();
        end
    endtask

    task automatic test_ptr_wrap();
        req_valid = 4'b0100;
        advance();
        req_valid = 4'b1001;
        settle();
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first: got %b want 1000", req_ready); end
        advance();
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_second: got %b want 0001", req_ready); end
        advance();
        req_valid = '1;
        settle();
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ptr_end: got %b want 0010", req_ready); end
        advance();
        req_valid = '0;
        for (int k = 0; k < LAT + 1; k++) begin
            settle();
            checks++; if (res_valid !== e_rvalid) begin errors++; $display("FAIL wrap_drain_valid_k%0d: got %b want %b", k, res_valid, e_rvalid); end
            checks++; if (inflight !== 2'(e_inflight)) begin errors++; $display("FAIL wrap_drain_inflight_k%0d: got %0d want %0d", k, inflight, e_inflight); end
            if (e_exit) begin
                checks++; if (res_p !== e_p) begin errors++; $display("FAIL wrap_drain_p_k%0d: got %0d want %0d", k, $signed(res_p), e_p); end
            end
            advance();
        end
    endtask

    task automatic test_reset_midflight();
        req_valid = '1;
        for (int k = 0; k < 3; k++) advance();
        rst = 1'b0;
        settle();
        checks++; if (inflight !== 2'd3) begin errors++; $display("FAIL mid_inflight_before: got %0d want 3", inflight); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready); end
        advance();
        rst = 1'b1; req_valid = '0;
        for (int k = 0; k < LAT; k++) begin
            settle();
            checks++; if (inflight !== 2'd0 || res_valid !== 4'b0000) begin errors++; $display("FAIL mid_flushed_k%0d: got inflight=%0d valid=%b want 0/0000", k, inflight, res_valid); end
            advance();
        end
        req_valid = 4'b0001;
        set_op(0, 21'd123456, -15'sd321);
        settle();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_new_grant: got %b want 0001", req_ready); end
        advance();
        req_valid = '0;
        for (int k = 1; k <= LAT; k++) begin
            settle();
            if (k == LAT) begin
                checks++; if (res_valid !== 4'b0001 || res_p !== -36'sd39629376) begin errors++; $display("FAIL mid_new_result: got %b/%0d want 0001/-39629376", res_valid, $signed(res_p)); end
            end else begin
                checks++; if (res_valid !== 4'b0000) begin errors++; $display("FAIL mid_new_early_k%0d: got %b want 0000", k, res_valid); end
            end
            advance();
        end
    endtask

    task automatic test_soak();
        int waitc [N];
        foreach (waitc[i]) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) set_op(i, 21'($urandom), 15'($urandom));
            res_ready = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            settle();
            checks++; if (req_ready !== e_ready) begin errors++; $display("FAIL soak_ready_c%0d: got %b want %b", c, req_ready, e_ready); end
            checks++; if (res_valid !== e_rvalid) begin errors++; $display("FAIL soak_valid_c%0d: got %b want %b", c, res_valid, e_rvalid); end
            checks++; if (mul_ce !== e_ce) begin errors++; $display("FAIL soak_ce_c%0d: got %b want %b", c, mul_ce, e_ce); end
            checks++; if (mul_a !== e_a || mul_b !== e_b) begin errors++; $display("FAIL soak_ops_c%0d: got %h/%h want %h/%h", c, mul_a, mul_b, e_a, e_b); end
            checks++; if (inflight !== 2'(e_inflight)) begin errors++; $display("FAIL soak_inflight_c%0d: got %0d want %0d", c, inflight, e_inflight); end
            if (e_exit) begin
                checks++; if (res_p !== e_p) begin errors++; $display("FAIL soak_res_p_c%0d: got %0d want %0d", c, $signed(res_p), e_p); end
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] || !req_valid[i]) begin
                    waitc[i] = 0;
                end else if (req_ready != '0) begin
                    waitc[i]++;
                    checks++; if (waitc[i] > N - 1) begin errors++; $display("FAIL soak_fairness_req%0d: got %0d grants waited want <= %0d", i, waitc[i], N - 1); end
                end
            end
            advance();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = '0; res_ready = '1; req_a = '0; req_b = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_contention();
        test_ptr_wrap();
        test_reset_midflight();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
